// File: rtl/axi4_sram_slave_if.sv
// AXI4 bundle between an M_AXI master and the SRAM slave.
// Member names mirror the S_AXI_* pins one-to-one.
interface axi4_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [7:0]              S_AXI_AWLEN;
  logic [2:0]              S_AXI_AWSIZE;
  logic [1:0]              S_AXI_AWBURST;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WLAST;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [7:0]              S_AXI_ARLEN;
  logic [2:0]              S_AXI_ARSIZE;
  logic [1:0]              S_AXI_ARBURST;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RLAST;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE,
    input  S_AXI_AWBURST, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST,
    input  S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE,
    input  S_AXI_ARBURST, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST,
    output S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE,
    output S_AXI_AWBURST, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST,
    output S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE,
    output S_AXI_ARBURST, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST,
    input  S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 burst slave over a word-addressed SRAM.
// Write and read engines run independently, one burst each.
module axi4_sram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input logic              clk,
  input logic              rst_n,
  axi4_sram_slave_if.slave s_axi
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LIMIT =
    ADDR_WIDTH'(MEM_WORDS * 4);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE, W_DATA, W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE, R_DATA
  } r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  function automatic logic cfg_err(
    input logic [7:0] len,
    input logic [2:0] size,
    input logic [1:0] burst
  );
    logic bad_wrap;
    bad_wrap = (burst == 2'b10) &&
      !(len == 8'd1 || len == 8'd3 ||
        len == 8'd7 || len == 8'd15);
    return (size > 3'd2) || (burst == 2'b11) || bad_wrap;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] step, mask, inc;
    step = ADDR_WIDTH'(1) << size;
    // wrap window is (len+1) beats of step bytes, aligned
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size)
           - ADDR_WIDTH'(1);
    inc  = a + step;
    next_addr = a;
    if (burst == 2'b01)
      next_addr = inc;
    else if (burst == 2'b10)
      next_addr = (a & ~mask) | (inc & mask);
  endfunction

  w_state_t              w_state, w_next;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_cfg_err, w_err, w_err_d;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic                  aw_hs, w_hs, b_hs;
  logic                  w_last_beat, w_commit;

  always_comb begin
    aw_hs       = s_axi.S_AXI_AWVALID & awready_q;
    w_hs        = s_axi.S_AXI_WVALID & wready_q;
    b_hs        = s_axi.S_AXI_BREADY & bvalid_q;
    w_last_beat = (w_cnt == w_len);
    w_commit    = w_hs & ~w_cfg_err & (w_addr < LIMIT);
    w_next      = w_state;
    w_err_d     = w_err;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          w_next  = W_DATA;
          w_err_d = cfg_err(s_axi.S_AXI_AWLEN,
                            s_axi.S_AXI_AWSIZE,
                            s_axi.S_AXI_AWBURST);
        end
      end
      W_DATA: begin
        if (w_hs) begin
          if (!w_commit ||
              (s_axi.S_AXI_WLAST != w_last_beat))
            w_err_d = 1'b1;
          if (w_last_beat)
            w_next = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs)
          w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      w_err     <= 1'b0;
    end else begin
      w_state   <= w_next;
      awready_q <= (w_next == W_IDLE);
      wready_q  <= (w_next == W_DATA);
      bvalid_q  <= (w_next == W_RESP);
      bresp_q   <= (w_next == W_RESP && w_err_d) ?
                   SLVERR : OKAY;
      w_err     <= w_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) begin
      w_addr    <= s_axi.S_AXI_AWADDR;
      w_len     <= s_axi.S_AXI_AWLEN;
      w_size    <= s_axi.S_AXI_AWSIZE;
      w_burst   <= s_axi.S_AXI_AWBURST;
      w_cnt     <= 8'd0;
      w_cfg_err <= cfg_err(s_axi.S_AXI_AWLEN,
                           s_axi.S_AXI_AWSIZE,
                           s_axi.S_AXI_AWBURST);
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
      w_cnt  <= w_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_commit) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (s_axi.S_AXI_WSTRB[i])
          mem[w_addr[IDX_W+1:2]][8*i +: 8] <=
            s_axi.S_AXI_WDATA[8*i +: 8];
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;

  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr, ld_addr;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_cfg_err;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  ar_hs, r_hs, r_last_beat;
  logic                  r_load, ld_err, ld_last;

  always_comb begin
    ar_hs       = s_axi.S_AXI_ARVALID & arready_q;
    r_hs        = rvalid_q & s_axi.S_AXI_RREADY;
    r_last_beat = (r_cnt == r_len);
    r_next      = r_state;
    unique case (r_state)
      R_IDLE: begin
        if (ar_hs)
          r_next = R_DATA;
      end
      R_DATA: begin
        if (r_hs && r_last_beat)
          r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
    // next beat is fetched on the handshake that retires the current one
    r_load  = ar_hs | (r_hs & ~r_last_beat);
    ld_addr = next_addr(r_addr, r_len, r_size, r_burst);
    ld_err  = r_cfg_err;
    ld_last = ((r_cnt + 8'd1) == r_len);
    if (ar_hs) begin
      ld_addr = s_axi.S_AXI_ARADDR;
      ld_err  = cfg_err(s_axi.S_AXI_ARLEN,
                        s_axi.S_AXI_ARSIZE,
                        s_axi.S_AXI_ARBURST);
      ld_last = (s_axi.S_AXI_ARLEN == 8'd0);
    end
    ld_err = ld_err | (ld_addr >= LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      rlast_q   <= 1'b0;
    end else begin
      r_state   <= r_next;
      arready_q <= (r_next == R_IDLE);
      rvalid_q  <= (r_next == R_DATA);
      if (r_load) begin
        rdata_q <= ld_err ? '0 : mem[ld_addr[IDX_W+1:2]];
        rresp_q <= ld_err ? SLVERR : OKAY;
        rlast_q <= ld_last;
      end else if (r_hs) begin
        rdata_q <= '0;
        rresp_q <= OKAY;
        rlast_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      r_len     <= s_axi.S_AXI_ARLEN;
      r_size    <= s_axi.S_AXI_ARSIZE;
      r_burst   <= s_axi.S_AXI_ARBURST;
      r_cfg_err <= cfg_err(s_axi.S_AXI_ARLEN,
                           s_axi.S_AXI_ARSIZE,
                           s_axi.S_AXI_ARBURST);
      r_addr    <= ld_addr;
      r_cnt     <= 8'd0;
    end else if (r_load) begin
      r_addr <= ld_addr;
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RLAST   = rlast_q;
endmodule
